// File: rtl/pr_dec_seq.sv
// rtl/pr_dec_seq.sv - index-to-one-hot decoder with timed hold and break-before-make gap
//
// Purpose:
//   Accepts a 3-bit line index through a valid/ready handshake.
//   Drives the matching one-hot line for HOLD consecutive cycles.
//   Then forces one all-zero gap cycle before any other line can assert.
//   Counts every accepted request modulo 256.
//
// Optional feature (macro PR_DEC_SEQ_SKID_EN):
//   Adds a one-entry skid buffer, so a request can be taken while a pulse is in
//   progress. Back-to-back pulses then repeat every HOLD+1 cycles instead of HOLD+2.
//
// Ports:
//   clk        in   1  rising-edge clock
//   rst        in   1  synchronous active-high reset
//   in_valid   in   1  request present
//   in_idx     in   3  encoded line index
//   in_ready   out  1  request accepted on this edge when in_valid is also high
//   out        out  8  registered one-hot line (zero when idle or in the gap)
//   out_valid  out  1  out is non-zero
//   busy       out  1  sequencer is not idle
//   dec_count  out  8  accepted-request count, wraps at 256

module pr_dec_seq #(
  parameter int unsigned HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [2:0] in_idx,
  output logic       in_ready,
  output logic [7:0] out,
  output logic       out_valid,
  output logic       busy,
  output logic [7:0] dec_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  // The counter holds the number of HOLD cycles still to come after the current one.
  localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);

  state_e     state_q, state_d;
  logic [7:0] out_q, out_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] count_q, count_d;
  logic       hs;

`ifdef PR_DEC_SEQ_SKID_EN
  logic       skid_vld_q, skid_vld_d;
  logic [2:0] skid_idx_q, skid_idx_d;

  assign in_ready = (state_q == S_IDLE) || !skid_vld_q;
`else
  assign in_ready = (state_q == S_IDLE);
`endif

  assign hs = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    count_d = count_q;
`ifdef PR_DEC_SEQ_SKID_EN
    skid_vld_d = skid_vld_q;
    skid_idx_d = skid_idx_q;
`endif

    if (hs) begin
      count_d = count_q + 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        out_d = 8'd0;
        if (hs) begin
          state_d = S_HOLD;
          out_d   = 8'd1 << in_idx;
          cnt_d   = HOLD_M1;
        end
      end

      S_HOLD: begin
`ifdef PR_DEC_SEQ_SKID_EN
        if (hs) begin
          skid_vld_d = 1'b1;
          skid_idx_d = in_idx;
        end
`endif
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d = S_GAP;
          out_d   = 8'd0;
        end
      end

      S_GAP: begin
        out_d   = 8'd0;
        state_d = S_IDLE;
`ifdef PR_DEC_SEQ_SKID_EN
        // A request taken during the gap would be stored and drained on this
        // same edge. It is therefore routed straight into HOLD, because the
        // buffer can only be empty here when nothing else is waiting.
        if (skid_vld_q) begin
          state_d    = S_HOLD;
          out_d      = 8'd1 << skid_idx_q;
          cnt_d      = HOLD_M1;
          skid_vld_d = 1'b0;
        end else if (hs) begin
          state_d = S_HOLD;
          out_d   = 8'd1 << in_idx;
          cnt_d   = HOLD_M1;
        end
`endif
      end

      default: begin
        state_d = S_IDLE;
        out_d   = 8'd0;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      out_q   <= 8'd0;
      cnt_q   <= 8'd0;
      count_q <= 8'd0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
    end
  end

`ifdef PR_DEC_SEQ_SKID_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_vld_q <= 1'b0;
      skid_idx_q <= 3'd0;
    end else begin
      skid_vld_q <= skid_vld_d;
      skid_idx_q <= skid_idx_d;
    end
  end
`endif

  assign out       = out_q;
  assign out_valid = |out_q;
  assign busy      = (state_q != S_IDLE);
  assign dec_count = count_q;

endmodule

// File: tb/tb_pr_dec_seq.sv
// tb/tb_pr_dec_seq.sv - bench for pr_dec_seq with HOLD=4 and HOLD=1 instances

module tb_pr_dec_seq;

  localparam int H0 = 4;
  localparam int H1 = 1;
  localparam int NEVER = -100;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [2:0] in_idx;
  logic       rdy [2];
  logic [7:0] dout[2];
  logic       ov  [2];
  logic       bsy [2];
  logic [7:0] cnt [2];

  always #5 clk = ~clk;

  pr_dec_seq #(.HOLD(H0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_idx(in_idx), .in_ready(rdy[0]),
    .out(dout[0]), .out_valid(ov[0]), .busy(bsy[0]), .dec_count(cnt[0])
  );

  pr_dec_seq #(.HOLD(H1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_idx(in_idx), .in_ready(rdy[1]),
    .out(dout[1]), .out_valid(ov[1]), .busy(bsy[1]), .dec_count(cnt[1])
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a timeline of pulses. Each accepted request starts at the
  // later of its handshake edge and the end of the previous pulse plus its gap.
  int       cyc = 0;
  int       s_last[2];
  int       s_prev[2];
  logic [2:0] i_last[2];
  logic [2:0] i_prev[2];
  int       m_cnt[2];
  bit       hs_seen[2];
  bit       skid_on;

  function automatic int hold_of(input int d);
    return (d == 0) ? H0 : H1;
  endfunction

  function automatic logic [7:0] exp_out(input int d);
    int h = hold_of(d);
    logic [7:0] one = 8'd1;
    if (cyc >= s_last[d] && cyc < s_last[d] + h) return one << i_last[d];
    if (cyc >= s_prev[d] && cyc < s_prev[d] + h) return one << i_prev[d];
    return 8'd0;
  endfunction

  function automatic bit exp_ready(input int d);
    if (skid_on) return s_last[d] <= cyc;
    return cyc >= s_last[d] + hold_of(d) + 1;
  endfunction

  function automatic bit exp_busy(input int d);
    return cyc <= s_last[d] + hold_of(d);
  endfunction

  task automatic tick(input bit v, input logic [2:0] idx, input bit r);
    bit hs[2];
    in_valid = v;
    in_idx   = idx;
    rst      = r;
    for (int d = 0; d < 2; d++) hs[d] = v && !r && exp_ready(d);
    @(posedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      hs_seen[d] = hs[d];
      if (r) begin
        s_last[d] = NEVER;
        s_prev[d] = NEVER;
        m_cnt[d]  = 0;
      end else if (hs[d]) begin
        s_prev[d] = s_last[d];
        i_prev[d] = i_last[d];
        s_last[d] = (s_last[d] + hold_of(d) + 1 > cyc) ? s_last[d] + hold_of(d) + 1 : cyc;
        i_last[d] = idx;
        m_cnt[d]  = (m_cnt[d] + 1) % 256;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    tick(1'b0, 3'd0, 1'b1);
    tick(1'b1, 3'd2, 1'b1);
    for (int d = 0; d < 2; d++) begin
      n_vec++;
      if (dout[d] !== 8'd0) begin n_err++; $display("FAIL reset_out dut%0d got %h want 00", d, dout[d]); end
      n_vec++;
      if (ov[d] !== 1'b0) begin n_err++; $display("FAIL reset_out_valid dut%0d got %b want 0", d, ov[d]); end
      n_vec++;
      if (bsy[d] !== 1'b0) begin n_err++; $display("FAIL reset_busy dut%0d got %b want 0", d, bsy[d]); end
      n_vec++;
      if (cnt[d] !== 8'd0) begin n_err++; $display("FAIL reset_count dut%0d got %0d want 0", d, cnt[d]); end
      n_vec++;
      if (rdy[d] !== 1'b1) begin n_err++; $display("FAIL reset_ready dut%0d got %b want 1", d, rdy[d]); end
    end
    tick(1'b0, 3'd0, 1'b0);
  endtask

  task automatic test_single();
    int n20 = 0;
    tick(1'b1, 3'd5, 1'b0);
    for (int k = 0; k < 9; k++) begin
      if (dout[0] === 8'h20) n20++;
      for (int d = 0; d < 2; d++) begin
        n_vec++;
        if (dout[d] !== exp_out(d)) begin n_err++; $display("FAIL single_out dut%0d cyc %0d got %h want %h", d, cyc, dout[d], exp_out(d)); end
        n_vec++;
        if (rdy[d] !== exp_ready(d)) begin n_err++; $display("FAIL single_ready dut%0d cyc %0d got %b want %b", d, cyc, rdy[d], exp_ready(d)); end
        n_vec++;
        if (cnt[d] !== 8'(m_cnt[d])) begin n_err++; $display("FAIL single_count dut%0d got %0d want %0d", d, cnt[d], m_cnt[d]); end
      end
      tick(1'b0, 3'd0, 1'b0);
    end
    n_vec++;
    if (n20 != H0) begin n_err++; $display("FAIL single_hold_len got %0d cycles want %0d", n20, H0); end
    n_vec++;
    if (cnt[0] !== 8'd1) begin n_err++; $display("FAIL single_final_count got %0d want 1", cnt[0]); end
  endtask

  task automatic test_sweep();
    int taken = 0;
    int guard = 0;
    int c0 = int'(cnt[0]);
    int rise[$];
    logic [7:0] seq[$];
    logic [7:0] prev = 8'd0;
    int period = skid_on ? H0 + 1 : H0 + 2;
    while ((taken < 8 || bsy[0] || bsy[1]) && guard < 200) begin
      tick(taken < 8, 3'(taken), 1'b0);
      if (hs_seen[0]) taken++;
      guard++;
      if (dout[0] !== 8'd0 && prev === 8'd0) begin rise.push_back(cyc); seq.push_back(dout[0]); end
      prev = dout[0];
      for (int d = 0; d < 2; d++) begin
        n_vec++;
        if (dout[d] !== exp_out(d)) begin n_err++; $display("FAIL sweep_out dut%0d cyc %0d got %h want %h", d, cyc, dout[d], exp_out(d)); end
        n_vec++;
        if (rdy[d] !== exp_ready(d)) begin n_err++; $display("FAIL sweep_ready dut%0d cyc %0d got %b want %b", d, cyc, rdy[d], exp_ready(d)); end
        n_vec++;
        if (bsy[d] !== exp_busy(d)) begin n_err++; $display("FAIL sweep_busy dut%0d cyc %0d got %b want %b", d, cyc, bsy[d], exp_busy(d)); end
      end
    end
    n_vec++;
    if (guard >= 200) begin n_err++; $display("FAIL sweep_timeout taken %0d want 8", taken); end
    n_vec++;
    if (seq.size() != 8) begin n_err++; $display("FAIL sweep_pulses got %0d want 8", seq.size()); end
    for (int k = 0; k < seq.size(); k++) begin
      n_vec++;
      if (seq[k] !== (8'd1 << k)) begin n_err++; $display("FAIL sweep_order pulse %0d got %h want %h", k, seq[k], 8'd1 << k); end
      if (k > 0) begin
        n_vec++;
        if (rise[k] - rise[k-1] != period) begin n_err++; $display("FAIL sweep_period got %0d want %0d", rise[k] - rise[k-1], period); end
      end
    end
    n_vec++;
    if (int'(cnt[0]) != (c0 + 8) % 256) begin n_err++; $display("FAIL sweep_count got %0d want %0d", cnt[0], (c0 + 8) % 256); end
  endtask

  task automatic test_hold1();
    int taken = 0;
    int guard = 0;
    logic [7:0] seq[$];
    logic [7:0] prev = dout[1];
    while ((taken < 2 || bsy[1]) && guard < 50) begin
      tick(taken < 2, (taken == 0) ? 3'd7 : 3'd0, 1'b0);
      if (hs_seen[1]) taken++;
      guard++;
      if (dout[1] !== 8'd0) seq.push_back(dout[1]);
      n_vec++;
      if (prev !== 8'd0 && dout[1] !== 8'd0 && dout[1] !== prev) begin n_err++; $display("FAIL hold1_overlap got %h after %h", dout[1], prev); end
      prev = dout[1];
      for (int d = 0; d < 2; d++) begin
        n_vec++;
        if (dout[d] !== exp_out(d)) begin n_err++; $display("FAIL hold1_out dut%0d cyc %0d got %h want %h", d, cyc, dout[d], exp_out(d)); end
      end
    end
    n_vec++;
    if (seq.size() != 2 || seq[0] !== 8'h80 || seq[1] !== 8'h01) begin
      n_err++; $display("FAIL hold1_seq got %0d pulse cycles, want 80 then 01", seq.size());
    end
    for (int k = 0; k < 8; k++) tick(1'b0, 3'd0, 1'b0);
  endtask

  task automatic test_reset_mid();
    tick(1'b1, 3'd3, 1'b0);
    tick(1'b0, 3'd0, 1'b0);
    n_vec++;
    if (dout[0] !== 8'h08) begin n_err++; $display("FAIL rstmid_pre got %h want 08", dout[0]); end
    tick(1'b1, 3'd4, 1'b1);
    for (int d = 0; d < 2; d++) begin
      n_vec++;
      if (dout[d] !== 8'd0) begin n_err++; $display("FAIL rstmid_out dut%0d got %h want 00", d, dout[d]); end
      n_vec++;
      if (bsy[d] !== 1'b0) begin n_err++; $display("FAIL rstmid_busy dut%0d got %b want 0", d, bsy[d]); end
      n_vec++;
      if (cnt[d] !== 8'd0) begin n_err++; $display("FAIL rstmid_count dut%0d got %0d want 0", d, cnt[d]); end
    end
    tick(1'b1, 3'd6, 1'b0);
    for (int k = 0; k < 8; k++) begin
      for (int d = 0; d < 2; d++) begin
        n_vec++;
        if (dout[d] !== exp_out(d)) begin n_err++; $display("FAIL rstmid_after dut%0d cyc %0d got %h want %h", d, cyc, dout[d], exp_out(d)); end
        n_vec++;
        if (cnt[d] !== 8'(m_cnt[d])) begin n_err++; $display("FAIL rstmid_count_after dut%0d got %0d want %0d", d, cnt[d], m_cnt[d]); end
      end
      tick(1'b0, 3'd0, 1'b0);
    end
  endtask

  task automatic test_wrap_random();
    int guard = 0;
    bit wrapped = 1'b0;
    logic [7:0] prev[2];
    for (int d = 0; d < 2; d++) prev[d] = dout[d];
    tick(1'b0, 3'd0, 1'b1);
    while (!wrapped && guard < 3000) begin
      tick(1'b1, 3'($urandom_range(0, 7)), 1'b0);
      guard++;
      if (hs_seen[0] && m_cnt[0] == 0) begin
        wrapped = 1'b1;
        n_vec++;
        if (cnt[0] !== 8'd0) begin n_err++; $display("FAIL wrap_count got %0d want 0", cnt[0]); end
      end
    end
    n_vec++;
    if (!wrapped) begin n_err++; $display("FAIL wrap_timeout count %0d", cnt[0]); end
    for (int k = 0; k < 1200; k++) begin
      tick($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), $urandom_range(0, 199) == 0);
      for (int d = 0; d < 2; d++) begin
        n_vec++;
        if (dout[d] !== exp_out(d)) begin n_err++; $display("FAIL rand_out dut%0d cyc %0d got %h want %h", d, cyc, dout[d], exp_out(d)); end
        n_vec++;
        if (rdy[d] !== exp_ready(d)) begin n_err++; $display("FAIL rand_ready dut%0d cyc %0d got %b want %b", d, cyc, rdy[d], exp_ready(d)); end
        n_vec++;
        if (bsy[d] !== exp_busy(d) || ov[d] !== (exp_out(d) != 8'd0)) begin
          n_err++; $display("FAIL rand_flags dut%0d cyc %0d busy %b/%b valid %b", d, cyc, bsy[d], exp_busy(d), ov[d]);
        end
        n_vec++;
        if (cnt[d] !== 8'(m_cnt[d])) begin n_err++; $display("FAIL rand_count dut%0d got %0d want %0d", d, cnt[d], m_cnt[d]); end
        n_vec++;
        if ($countones(dout[d]) > 1 || (prev[d] !== 8'd0 && dout[d] !== 8'd0 && dout[d] !== prev[d])) begin
          n_err++; $display("FAIL rand_onehot dut%0d got %h prev %h", d, dout[d], prev[d]);
        end
        prev[d] = dout[d];
      end
    end
  endtask

  initial begin
`ifdef PR_DEC_SEQ_SKID_EN
    skid_on = 1'b1;
`else
    skid_on = 1'b0;
`endif
    for (int d = 0; d < 2; d++) begin
      s_last[d] = NEVER;
      s_prev[d] = NEVER;
      i_last[d] = 3'd0;
      i_prev[d] = 3'd0;
      m_cnt[d]  = 0;
      hs_seen[d] = 1'b0;
    end
    rst = 1'b1;
    in_valid = 1'b0;
    in_idx = 3'd0;
    #1;
    test_reset();
    test_single();
    test_sweep();
    test_hold1();
    test_reset_mid();
    test_wrap_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
